add64_pipe2: RTL and testbench



---
 rtl/add64_pipe2_pkg.sv | 25 ++
 rtl/add64_pipe2_if.sv | 32 +++
 rtl/cla32bits.sv | 44 ++++
 rtl/add64_pipe2.sv | 124 ++++++++++++
 tb/tb_add64_pipe2.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/add64_pipe2_pkg.sv
// add64_pipe2_pkg: widths and pipeline record types shared by the add64_pipe2 slice.
// The sub field and ovf are only meaningful when ADD64_PIPE2_SUB_EN is defined.
package add64_pipe2_pkg;

   localparam int ADD64_N     = 64;
   localparam int ADD64_M     = 32;
   localparam int ADD64_TAG_W = 4;

   typedef struct packed {
      logic [ADD64_M-1:0]         lo;
      logic                       c32;
      logic [ADD64_N-ADD64_M-1:0] a_hi;
      logic [ADD64_N-ADD64_M-1:0] b_hi;
      logic [ADD64_TAG_W-1:0]     tag;
      logic                       sub;
   } s1_t;

   typedef struct packed {
      logic [ADD64_N-1:0]     sum;
      logic                   cout;
      logic [ADD64_TAG_W-1:0] tag;
      logic                   ovf;
   } res_t;

endpackage

// File: rtl/add64_pipe2_if.sv
// add64_pipe2_if: operand and result valid/ready channels of the pipelined adder.
// ADD64_PIPE2_SUB_EN adds in_sub and out_ovf to both modports.
interface add64_pipe2_if;
   import add64_pipe2_pkg::*;

   logic                   in_valid;
   logic                   in_ready;
   logic [ADD64_N-1:0]     in_a;
   logic [ADD64_N-1:0]     in_b;
   logic                   in_cin;
   logic [ADD64_TAG_W-1:0] in_tag;
   logic                   out_valid;
   logic                   out_ready;
   logic [ADD64_N-1:0]     out_sum;
   logic                   out_cout;
   logic [ADD64_TAG_W-1:0] out_tag;
`ifdef ADD64_PIPE2_SUB_EN
   logic                   in_sub;
   logic                   out_ovf;

   modport master (output in_valid, in_a, in_b, in_cin, in_tag, in_sub, out_ready,
                   input  in_ready, out_valid, out_sum, out_cout, out_tag, out_ovf);
   modport slave  (input  in_valid, in_a, in_b, in_cin, in_tag, in_sub, out_ready,
                   output in_ready, out_valid, out_sum, out_cout, out_tag, out_ovf);
`else
   modport master (output in_valid, in_a, in_b, in_cin, in_tag, out_ready,
                   input  in_ready, out_valid, out_sum, out_cout, out_tag);
   modport slave  (input  in_valid, in_a, in_b, in_cin, in_tag, out_ready,
                   output in_ready, out_valid, out_sum, out_cout, out_tag);
`endif

endinterface

// File: rtl/cla32bits.sv
// cla32bits: 32-bit carry-lookahead adder made of eight 4-bit lookahead groups.
// gen/prop are the block generate/propagate for a higher lookahead level.
module cla32bits (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout,
   output logic        gen,
   output logic        prop
);

   logic [31:0] g;
   logic [31:0] p;
   logic [32:0] c;
   logic [7:0]  gg;
   logic [7:0]  gp;

   always_comb begin
      g    = a & b;
      p    = a ^ b;
      gg   = '0;
      gp   = '0;
      c    = '0;
      gen  = 1'b0;
      c[0] = cin;
      for (int k = 0; k < 8; k++) begin
         gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         gp[k] = &p[4*k +: 4];
         // In-group carries look ahead from the group carry-in only
         c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
         c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
         gen      = gg[k] | (gp[k] & gen);
      end
      sum  = p ^ c[31:0];
      cout = c[32];
      prop = &p;
   end

endmodule

// File: rtl/add64_pipe2.sv
// add64_pipe2: two-stage 64-bit adder with valid/ready on both sides; low half in stage 1,
// high half in stage 2. Define ADD64_PIPE2_SUB_EN for subtract mode and out_ovf.
module add64_pipe2
   import add64_pipe2_pkg::*;
#(
   parameter int N     = ADD64_N,
   parameter int M     = ADD64_M,
   parameter int TAG_W = ADD64_TAG_W
) (
   input logic          clk,
   input logic          rst_n,
   add64_pipe2_if.slave bus
);

   if (N != ADD64_N || M != ADD64_M || TAG_W != ADD64_TAG_W) begin : g_width_chk
      $error("add64_pipe2: N, M and TAG_W must match add64_pipe2_pkg");
   end

   function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

   logic           adv2;
   logic           acc1;
   logic           ld2;
   logic           vld_p1;
   logic           vld_p2;
   logic           sub_p0;
   logic           cin_p0;
   logic [N-1:0]   b_p0;
   logic [M-1:0]   lo_sum_p0;
   logic           lo_cout_p0;
   logic [N-M-1:0] hi_sum_p1;
   logic           hi_cout_p1;
   logic           lo_gen_unused, lo_prop_unused, hi_gen_unused, hi_prop_unused;
   logic           sub_unused;
   s1_t            s1_d;
   s1_t            s1_p1;
   res_t           res_d;
   res_t           res_p2;

   assign adv2         = ~vld_p2 | bus.out_ready;
   assign bus.in_ready = ~vld_p1 | adv2;
   assign acc1         = bus.in_valid & bus.in_ready;
   assign ld2          = vld_p1 & adv2;

`ifdef ADD64_PIPE2_SUB_EN
   assign sub_p0 = bus.in_sub;
`else
   assign sub_p0 = 1'b0;
`endif

   // ---- stage 0 -> 1: low half, carry into bit M captured as c32
   assign b_p0   = sub_p0 ? ~bus.in_b : bus.in_b;
   assign cin_p0 = bus.in_cin | sub_p0;

   cla32bits u_lo (
      .a    (bus.in_a[M-1:0]),
      .b    (b_p0[M-1:0]),
      .cin  (cin_p0),
      .sum  (lo_sum_p0),
      .cout (lo_cout_p0),
      .gen  (lo_gen_unused),
      .prop (lo_prop_unused)
   );

   always_comb begin
      s1_d      = '0;
      s1_d.lo   = lo_sum_p0;
      s1_d.c32  = lo_cout_p0;
      s1_d.a_hi = bus.in_a[N-1:M];
      s1_d.b_hi = b_p0[N-1:M];
      s1_d.tag  = bus.in_tag;
      s1_d.sub  = sub_p0;
   end

   // ---- stage 1 -> 2: high half consumes the registered carry
   cla32bits u_hi (
      .a    (s1_p1.a_hi),
      .b    (s1_p1.b_hi),
      .cin  (s1_p1.c32),
      .sum  (hi_sum_p1),
      .cout (hi_cout_p1),
      .gen  (hi_gen_unused),
      .prop (hi_prop_unused)
   );

   always_comb begin
      res_d      = '0;
      res_d.sum  = {hi_sum_p1, s1_p1.lo};
      res_d.cout = hi_cout_p1;
      res_d.tag  = s1_p1.tag;
      res_d.ovf  = signed_ovf(s1_p1.a_hi[N-M-1], s1_p1.b_hi[N-M-1], hi_sum_p1[N-M-1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         s1_p1  <= '0;
         res_p2 <= '0;
      end else begin
         vld_p1 <= acc1 | (vld_p1 & ~adv2);
         vld_p2 <= ld2 | (vld_p2 & ~bus.out_ready);
         if (acc1) s1_p1 <= s1_d;
         if (ld2)  res_p2 <= res_d;
      end
   end

   // ---- stage 2: result register drives the consumer directly
   assign bus.out_valid = vld_p2;
   assign bus.out_sum   = res_p2.sum;
   assign bus.out_cout  = res_p2.cout;
   assign bus.out_tag   = res_p2.tag;
   assign sub_unused    = s1_p1.sub;

`ifdef ADD64_PIPE2_SUB_EN
   assign bus.out_ovf = res_p2.ovf;
`else
   logic ovf_unused;
   assign ovf_unused = res_p2.ovf;
`endif

endmodule

// File: tb/tb_add64_pipe2.sv
// tb_add64_pipe2: directed and random checks of add64_pipe2 against a wide-arithmetic model.
// Build with ADD64_PIPE2_SUB_EN defined to cover subtract mode and out_ovf.
module tb_add64_pipe2;
   import add64_pipe2_pkg::*;

   typedef struct {
      int          stp;
      logic [63:0] sum;
      logic        cout;
      logic [3:0]  tag;
      logic        ovf;
   } exp_t;

   logic clk;
   logic rst_n;

   add64_pipe2_if bus ();

   add64_pipe2 #(.N(ADD64_N), .M(ADD64_M), .TAG_W(ADD64_TAG_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t        q[$];
   int          nasrt = 0;
   int          nfail = 0;
   int          npop = 0;
   int          cur_step = 0;
   logic        last_in;
   logic        prev_hold;
   logic        sub_v;
   logic [63:0] prev_sum, last_sum;
   logic        prev_cout, last_cout;
   logic [3:0]  prev_tag, last_tag;
`ifdef ADD64_PIPE2_SUB_EN
   logic        last_ovf;
`endif

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nasrt++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain wide arithmetic, signed range test for overflow
   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic cin,
                                  input logic [3:0] tag, input logic sub);
      exp_t              e;
      logic [64:0]       w;
      logic signed [65:0] r, rt;
      if (sub) begin
         e.sum  = a - b;
         e.cout = (a >= b);
         r = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
      end else begin
         w = {1'b0, a} + {1'b0, b} + {64'd0, cin};
         e.sum  = w[63:0];
         e.cout = w[64];
         r = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}) + $signed({65'd0, cin});
      end
      rt    = 66'($signed(r[63:0]));
      e.ovf = (r != rt);
      e.tag = tag;
      e.stp = 0;
      return e;
   endfunction

   function automatic logic [63:0] rnd64();
      case ($urandom_range(0, 4))
         0:       return 64'd0;
         1:       return '1;
         2:       return 64'h0000_0000_FFFF_FFFF;
         3:       return 64'h7FFF_FFFF_FFFF_FFFF;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   function automatic logic rsub();
`ifdef ADD64_PIPE2_SUB_EN
      return 1'($urandom_range(0, 1));
`else
      return 1'b0;
`endif
   endfunction

   task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b, input logic cin,
                        input logic [3:0] tag, input logic sub);
      bus.in_valid = v;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = cin;
      bus.in_tag   = tag;
      sub_v        = sub;
`ifdef ADD64_PIPE2_SUB_EN
      bus.in_sub   = sub;
`endif
   endtask

   // One clock: sample on the falling edge, score handshakes, return 1 time unit after the rise
   task automatic step();
      exp_t e;
      logic hin, hout, exp_ov;
      @(negedge clk);
      exp_ov = 1'b0;
      if (q.size() > 0) exp_ov = (q[0].stp + 2 <= cur_step);
      chk("in_ready", 64'(bus.in_ready), 64'((q.size() < 2) || bus.out_ready));
      chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
      if (prev_hold) begin
         chk("hold_sum", bus.out_sum, prev_sum);
         chk("hold_cout", 64'(bus.out_cout), 64'(prev_cout));
         chk("hold_tag", 64'(bus.out_tag), 64'(prev_tag));
      end
      hin  = bus.in_valid & bus.in_ready;
      hout = bus.out_valid & bus.out_ready;
      if (hout && q.size() > 0) begin
         e = q.pop_front();
         npop++;
         chk("sum", bus.out_sum, e.sum);
         chk("cout", 64'(bus.out_cout), 64'(e.cout));
         chk("tag", 64'(bus.out_tag), 64'(e.tag));
`ifdef ADD64_PIPE2_SUB_EN
         chk("ovf", 64'(bus.out_ovf), 64'(e.ovf));
         last_ovf = bus.out_ovf;
`endif
         last_sum  = bus.out_sum;
         last_cout = bus.out_cout;
         last_tag  = bus.out_tag;
      end
      if (hin) begin
         e = model(bus.in_a, bus.in_b, bus.in_cin, bus.in_tag, sub_v);
         e.stp = cur_step;
         q.push_back(e);
      end
      prev_hold = bus.out_valid & ~bus.out_ready;
      prev_sum  = bus.out_sum;
      prev_cout = bus.out_cout;
      prev_tag  = bus.out_tag;
      last_in   = hin;
      cur_step++;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin,
                       input logic [3:0] tag, input logic sub);
      int n = 0;
      drive(1'b1, a, b, cin, tag, sub);
      do begin
         step();
         n++;
      end while (!last_in && n < 20);
      chk("send_accepted", 64'(last_in), 64'd1);
      drive(1'b0, a, b, cin, tag, sub);
   endtask

   task automatic drain();
      int n = 0;
      bus.out_ready = 1'b1;
      while (q.size() > 0 && n < 50) begin
         step();
         n++;
      end
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   initial begin
      int p0;
      int acc;
      int nb;
      rst_n     = 1'b1;
      last_in   = 1'b0;
      prev_hold = 1'b0;
      bus.out_ready = 1'b1;
      drive(1'b0, 64'd0, 64'd0, 1'b0, 4'd0, 1'b0);
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_sum", bus.out_sum, 64'd0);
      chk("rst_out_cout", 64'(bus.out_cout), 64'd0);
      chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
      rst_n = 1'b1;

      // Carry out of bit 31 must reach the high half
      send(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 4'h1, 1'b0);
      drain();
      chk("t1_sum", last_sum, 64'h0000_0001_0000_0000);
      chk("t1_cout", 64'(last_cout), 64'd0);
      chk("t1_tag", 64'(last_tag), 64'h1);

      // Wrap-around cases
      send('1, 64'd0, 1'b1, 4'h2, 1'b0);
      drain();
      chk("wrap1_sum", last_sum, 64'd0);
      chk("wrap1_cout", 64'(last_cout), 64'd1);
      send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 4'h3, 1'b0);
      drain();
      chk("wrap2_sum", last_sum, 64'd0);
      chk("wrap2_cout", 64'(last_cout), 64'd1);

      // Back-to-back stream at full rate
      p0 = npop;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 64'(i), 64'(i) << 40, 1'b0, 4'(i), 1'b0);
         step();
         chk("b2b_accept", 64'(last_in), 64'd1);
      end
      drive(1'b0, 64'd0, 64'd0, 1'b0, 4'd0, 1'b0);
      drain();
      chk("b2b_count", 64'(npop - p0), 64'd16);
      chk("b2b_last_tag", 64'(last_tag), 64'hF);

      // Backpressure: only two beats fit while the consumer stalls
      p0  = npop;
      acc = 0;
      nb  = 0;
      bus.out_ready = 1'b0;
      drive(1'b1, rnd64(), rnd64(), 1'b0, 4'(nb), 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         if (last_in) begin
            acc++;
            nb++;
            drive(1'b1, rnd64(), rnd64(), 1'b1, 4'(nb), 1'b0);
         end
      end
      chk("bp_accepted", 64'(acc), 64'd2);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      drive(1'b0, 64'd0, 64'd0, 1'b0, 4'd0, 1'b0);
      drain();
      chk("bp_popped", 64'(npop - p0), 64'd2);

      // Asynchronous reset with both stages occupied
      bus.out_ready = 1'b1;
      send(rnd64(), rnd64(), 1'b0, 4'h5, 1'b0);
      drive(1'b1, rnd64(), rnd64(), 1'b1, 4'h6, 1'b0);
      step();
      chk("mf_second_accept", 64'(last_in), 64'd1);
      drive(1'b0, 64'd0, 64'd0, 1'b0, 4'd0, 1'b0);
      bus.out_ready = 1'b0;
      #1;
      chk("mf_full_in_ready", 64'(bus.in_ready), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("mf_out_valid", 64'(bus.out_valid), 64'd0);
      chk("mf_in_ready", 64'(bus.in_ready), 64'd1);
      chk("mf_out_sum", bus.out_sum, 64'd0);
      q.delete();
      prev_hold = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      repeat (4) step();

`ifdef ADD64_PIPE2_SUB_EN
      send(64'd5, 64'd7, 1'b0, 4'h7, 1'b1);
      drain();
      chk("sub_sum", last_sum, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("sub_cout", 64'(last_cout), 64'd0);
      chk("sub_ovf0", 64'(last_ovf), 64'd0);
      send(64'h8000_0000_0000_0000, 64'd1, 1'b0, 4'h8, 1'b1);
      drain();
      chk("sub_ovf1", 64'(last_ovf), 64'd1);
      chk("sub_ovf_sum", last_sum, 64'h7FFF_FFFF_FFFF_FFFF);
`endif

      // Random stream with random consumer stalls
      p0 = npop;
      nb = 0;
      for (int i = 0; i < 400; i++) begin
         if (last_in || !bus.in_valid) begin
            drive($urandom_range(0, 3) != 0, rnd64(), rnd64(), 1'($urandom_range(0, 1)),
                  4'($urandom), rsub());
         end
         if (last_in) nb++;
         bus.out_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      if (last_in) nb++;
      drive(1'b0, 64'd0, 64'd0, 1'b0, 4'd0, 1'b0);
      drain();
      chk("rand_no_loss", 64'(npop - p0), 64'(nb));

      $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
      $finish;
   end

endmodule
